// File: rtl/pipelined_datapath.sv
// Three-stage datapath: issue/operand latch (S1), execute/memory (S2), writeback.
// Operands are bypassed from S1 (ALU) and S2 (writeback); a load followed by a dependent op stalls one cycle.
module pipelined_datapath #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 16,
    parameter  int DEPTH = 256,
    localparam int RAW   = $clog2(NREGS),
    localparam int DAW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RAW-1:0]   in_ra,
    input  logic [RAW-1:0]   in_rb,
    input  logic [RAW-1:0]   in_wa,
    input  logic             in_wen,
    input  logic             in_rf_s,
    input  logic [2:0]       in_alu_s,
    input  logic [DAW-1:0]   in_d_addr,
    input  logic             in_d_wr,
    output logic             out_valid,
    output logic             out_wen,
    output logic [RAW-1:0]   out_wa,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    logic [NREGS-1:0][WIDTH-1:0] r_rf;
    logic [WIDTH-1:0]            r_mem [DEPTH];
    logic [WIDTH-1:0]            r_mem_q;

    logic             r_s1_vld, r_s1_wen, r_s1_rf_s, r_s1_d_wr;
    logic [RAW-1:0]   r_s1_wa;
    logic [2:0]       r_s1_alu_s;
    logic [DAW-1:0]   r_s1_d_addr;
    logic [WIDTH-1:0] r_s1_a, r_s1_b;

    logic             r_s2_vld, r_s2_wen, r_s2_rf_s;
    logic [RAW-1:0]   r_s2_wa;
    logic [WIDTH-1:0] r_s2_alu;

    logic             w_ld_use, w_acc;
    logic [WIDTH-1:0] w_alu, w_wb, w_opa, w_opb;

    always_comb begin
        w_alu = '0;
        case (r_s1_alu_s)
            3'd0:    w_alu = '0;
            3'd1:    w_alu = r_s1_a + r_s1_b;
            3'd2:    w_alu = r_s1_a - r_s1_b;
            3'd3:    w_alu = r_s1_a;
            3'd4:    w_alu = r_s1_a ^ r_s1_b;
            3'd5:    w_alu = r_s1_a | r_s1_b;
            3'd6:    w_alu = r_s1_a & r_s1_b;
            default: w_alu = r_s1_a + WIDTH'(1);
        endcase
    end

    assign w_wb = r_s2_rf_s ? r_mem_q : r_s2_alu;

    // A load in S1 has no data yet; the consumer waits one cycle and picks it up from S2.
    assign w_ld_use = r_s1_vld && r_s1_wen && r_s1_rf_s &&
                      (in_ra == r_s1_wa || in_rb == r_s1_wa);
    assign in_ready = !w_ld_use;
    assign w_acc    = in_valid && !w_ld_use;

    // Later assignments win: S1 ALU result beats S2 writeback beats RF.
    always_comb begin
        w_opa = r_rf[in_ra];
        w_opb = r_rf[in_rb];
        if (r_s2_vld && r_s2_wen && r_s2_wa == in_ra) w_opa = w_wb;
        if (r_s2_vld && r_s2_wen && r_s2_wa == in_rb) w_opb = w_wb;
        if (r_s1_vld && r_s1_wen && !r_s1_rf_s && r_s1_wa == in_ra) w_opa = w_alu;
        if (r_s1_vld && r_s1_wen && !r_s1_rf_s && r_s1_wa == in_rb) w_opb = w_alu;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld    <= 1'b0;
            r_s1_wen    <= 1'b0;
            r_s1_rf_s   <= 1'b0;
            r_s1_d_wr   <= 1'b0;
            r_s1_wa     <= '0;
            r_s1_alu_s  <= '0;
            r_s1_d_addr <= '0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
        end else begin
            r_s1_vld    <= w_acc;
            r_s1_wen    <= in_wen;
            r_s1_rf_s   <= in_rf_s;
            r_s1_d_wr   <= in_d_wr;
            r_s1_wa     <= in_wa;
            r_s1_alu_s  <= in_alu_s;
            r_s1_d_addr <= in_d_addr;
            r_s1_a      <= w_opa;
            r_s1_b      <= w_opb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_wen  <= 1'b0;
            r_s2_rf_s <= 1'b0;
            r_s2_wa   <= '0;
            r_s2_alu  <= '0;
        end else begin
            r_s2_vld  <= r_s1_vld;
            r_s2_wen  <= r_s1_vld && r_s1_wen;
            r_s2_rf_s <= r_s1_rf_s;
            r_s2_wa   <= r_s1_wa;
            r_s2_alu  <= w_alu;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else if (r_s2_vld && r_s2_wen) begin
            r_rf[r_s2_wa] <= w_wb;
        end
    end

    // Read returns the old word; a load issued right after a store sees it a cycle later.
    always_ff @(posedge clk) begin
        if (r_s1_vld && r_s1_d_wr) r_mem[r_s1_d_addr] <= r_s1_a;
        r_mem_q <= r_mem[r_s1_d_addr];
    end

    assign out_valid = r_s2_vld;
    assign out_wen   = r_s2_wen;
    assign out_wa    = r_s2_wa;
    assign out_data  = w_wb;
    assign out_zero  = (w_wb == '0);

endmodule

// File: tb/tb_pipelined_datapath.sv
// Scoreboard bench: an architectural model predicts each micro-op's writeback at issue time.
module tb_pipelined_datapath;

    logic        clk, rst_n, in_valid, in_ready;
    logic [3:0]  in_ra, in_rb, in_wa;
    logic        in_wen, in_rf_s, in_d_wr;
    logic [2:0]  in_alu_s;
    logic [7:0]  in_d_addr;
    logic        out_valid, out_wen, out_zero;
    logic [3:0]  out_wa;
    logic [15:0] out_data;

    pipelined_datapath dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ra(in_ra), .in_rb(in_rb), .in_wa(in_wa), .in_wen(in_wen),
        .in_rf_s(in_rf_s), .in_alu_s(in_alu_s), .in_d_addr(in_d_addr),
        .in_d_wr(in_d_wr), .out_valid(out_valid), .out_wen(out_wen),
        .out_wa(out_wa), .out_data(out_data), .out_zero(out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        wen;
        logic [3:0]  wa;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_rf [16];
    logic [15:0] m_mem [256];
    int          n_cmp = 0, n_err = 0, last_stall = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] wa,
                         input logic wen, input logic rf_s, input logic [2:0] alu,
                         input logic [7:0] addr, input logic dwr);
        int          st;
        logic [15:0] a, b, r, rd, d;
        exp_t        e;
        st = 0;
        @(negedge clk);
        in_ra = ra; in_rb = rb; in_wa = wa; in_wen = wen; in_rf_s = rf_s;
        in_alu_s = alu; in_d_addr = addr; in_d_wr = dwr; in_valid = 1'b1;
        #1;
        while (!in_ready && st < 8) begin
            st++;
            @(negedge clk);
            #1;
        end
        last_stall = st;
        if (!in_ready) begin
            chk("issue_timeout", 32'(in_ready), 32'd1);
        end else begin
            a = m_rf[ra];
            b = m_rf[rb];
            case (alu)
                3'd0: r = 16'h0;
                3'd1: r = a + b;
                3'd2: r = a - b;
                3'd3: r = a;
                3'd4: r = a ^ b;
                3'd5: r = a | b;
                3'd6: r = a & b;
                default: r = a + 16'h1;
            endcase
            rd = m_mem[addr];
            if (dwr) m_mem[addr] = a;
            d = rf_s ? rd : r;
            if (wen) m_rf[wa] = d;
            e.wen = wen; e.wa = wa; e.data = d;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Idle cycles drive write-looking junk to prove bubbles never write.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0; in_wen = 1'b1; in_d_wr = 1'b1;
            in_d_addr = 8'd27; in_wa = 4'd4; in_ra = 4'd9;
        end
    endtask

    // Shift-and-add a constant into register r; every step depends on the previous one.
    task automatic const_load(input logic [3:0] r, input logic [15:0] val);
        issue(4'd15, 4'd15, r, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
        for (int i = 15; i >= 0; i--) begin
            issue(r, r, r, 1'b1, 1'b0, 3'd1, 8'd0, 1'b0);
            if (val[i]) issue(r, r, r, 1'b1, 1'b0, 3'd7, 8'd0, 1'b0);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_wen", 32'(out_wen), 32'd0);
        chk("rst_out_wa", 32'(out_wa), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_wen", 32'(out_wen), 32'(e.wen));
                if (e.wen) chk("out_wa", 32'(out_wa), 32'(e.wa));
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_zero", 32'(out_zero), 32'(e.data == 16'h0));
            end
        end
    end

    initial begin
        int t;
        for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h0;
        in_valid = 0; in_ra = 0; in_rb = 0; in_wa = 0; in_wen = 0;
        in_rf_s = 0; in_alu_s = 0; in_d_addr = 0; in_d_wr = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back forwarding: 1, 2, 1 with no stall
        issue(4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 3'd7, 8'd0, 1'b0);
        chk("fwd_stall0", 32'(last_stall), 32'd0);
        issue(4'd1, 4'd1, 4'd2, 1'b1, 1'b0, 3'd1, 8'd0, 1'b0);
        chk("fwd_stall1", 32'(last_stall), 32'd0);
        issue(4'd2, 4'd1, 4'd3, 1'b1, 1'b0, 3'd2, 8'd0, 1'b0);
        chk("fwd_stall2", 32'(last_stall), 32'd0);

        // load/store chain through mem[27] and mem[42]
        const_load(4'd10, 16'h21BA);
        issue(4'd10, 4'd0, 4'd0, 1'b0, 1'b0, 3'd3, 8'd27, 1'b1);
        issue(4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 3'd0, 8'd27, 1'b0);
        issue(4'd4, 4'd0, 4'd0, 1'b0, 1'b0, 3'd3, 8'd42, 1'b1);
        chk("store_after_load_stall", 32'(last_stall), 32'd1);
        issue(4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 3'd0, 8'd42, 1'b0);
        chk("st_ld_model", 32'(m_rf[5]), 32'h21BA);

        // load-use: one-cycle bubble, 29100 + 29100 = 58200
        const_load(4'd11, 16'd29100);
        issue(4'd11, 4'd0, 4'd0, 1'b0, 1'b0, 3'd3, 8'd60, 1'b1);
        idle(2);
        issue(4'd0, 4'd0, 4'd6, 1'b1, 1'b1, 3'd0, 8'd60, 1'b0);
        issue(4'd6, 4'd6, 4'd7, 1'b1, 1'b0, 3'd1, 8'd0, 1'b0);
        chk("load_use_stall", 32'(last_stall), 32'd1);
        chk("load_use_model", 32'(m_rf[7]), 32'hE358);

        // wrap and zero
        issue(4'd15, 4'd0, 4'd14, 1'b1, 1'b0, 3'd7, 8'd0, 1'b0);
        issue(4'd15, 4'd14, 4'd8, 1'b1, 1'b0, 3'd2, 8'd0, 1'b0);
        issue(4'd8, 4'd0, 4'd9, 1'b1, 1'b0, 3'd7, 8'd0, 1'b0);
        issue(4'd15, 4'd14, 4'd12, 1'b1, 1'b0, 3'd2, 8'd0, 1'b0);
        issue(4'd8, 4'd10, 4'd13, 1'b1, 1'b0, 3'd4, 8'd0, 1'b0);
        issue(4'd13, 4'd10, 4'd13, 1'b1, 1'b0, 3'd5, 8'd0, 1'b0);
        issue(4'd13, 4'd11, 4'd13, 1'b1, 1'b0, 3'd6, 8'd0, 1'b0);

        // gapped dependent ops exercise S2 bypass and same-cycle RF read/write
        for (int g = 1; g <= 2; g++) begin
            issue(4'd3, 4'd3, 4'd1, 1'b1, 1'b0, 3'd7, 8'd0, 1'b0);
            idle(g);
            issue(4'd1, 4'd1, 4'd2, 1'b1, 1'b0, 3'd1, 8'd0, 1'b0);
            idle(g);
            issue(4'd2, 4'd1, 4'd3, 1'b1, 1'b0, 3'd2, 8'd0, 1'b0);
            issue(4'd0, 4'd0, 4'd6, 1'b1, 1'b1, 3'd0, 8'd42, 1'b0);
            idle(g);
            issue(4'd6, 4'd3, 4'd7, 1'b1, 1'b0, 3'd1, 8'd0, 1'b0);
            chk("gap_no_stall", 32'(last_stall), 32'd0);
        end
        issue(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 3'd0, 8'd27, 1'b0);
        for (int i = 0; i < 16; i++)
            issue(4'(i), 4'd0, 4'd0, 1'b0, 1'b0, 3'd3, 8'd0, 1'b0);

        // reset mid-stream with ALU ops in flight
        issue(4'd7, 4'd7, 4'd1, 1'b1, 1'b0, 3'd1, 8'd0, 1'b0);
        issue(4'd1, 4'd7, 4'd2, 1'b1, 1'b0, 3'd1, 8'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
        #1;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++)
            issue(4'(i), 4'd0, 4'd0, 1'b0, 1'b0, 3'd3, 8'd0, 1'b0);
        issue(4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 3'd0, 8'd42, 1'b0);

        t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
